// File: rtl/alu_shift_seq.sv
// Multi-cycle iterative shifter: SLL/SRL/SRA/ROR, at most SHIFT_STEP bits per cycle.
// Request/response over valid/ready; one operation in flight at a time.
module alu_shift_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned SHIFT_STEP  = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            op_i,
  input  logic                  use_imm_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [5:0]            imm_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHIFT_WIDTH:0] StepMax = (SHIFT_WIDTH+1)'(SHIFT_STEP);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [SHIFT_WIDTH-1:0]  rem_q, rem_d;
  logic [1:0]              op_q, op_d;
  logic                    sign_q, sign_d;

  logic                    accept;
  logic [SHIFT_WIDTH-1:0]  amount;
  logic [SHIFT_WIDTH-1:0]  step_k;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [2*DATA_WIDTH-1:0] wide;

  assign req_ready_o = (state_q == StIdle) & ~flush_i & arst_ni;
  assign rsp_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = result_q;

  assign accept = req_valid_i & req_ready_o;
  assign amount = use_imm_i ? imm_i[SHIFT_WIDTH-1:0] : rs2_data_i[SHIFT_WIDTH-1:0];

  always_comb begin
    step_k = rem_q;
    if ({1'b0, rem_q} > StepMax) begin
      step_k = StepMax[SHIFT_WIDTH-1:0];
    end
  end

  // Wide concatenation supplies the fill bits for SRA (sign) and ROR (wrapped data).
  always_comb begin
    wide    = '0;
    shifted = data_q;
    unique case (op_q)
      2'b00: shifted = data_q << step_k;
      2'b01: shifted = data_q >> step_k;
      2'b10: begin
        wide    = {{DATA_WIDTH{sign_q}}, data_q} >> step_k;
        shifted = wide[DATA_WIDTH-1:0];
      end
      2'b11: begin
        wide    = {data_q, data_q} >> step_k;
        shifted = wide[DATA_WIDTH-1:0];
      end
      default: shifted = data_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    if (flush_i) begin
      state_d = StIdle;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_d = rs1_data_i;
            op_d   = op_i;
            sign_d = rs1_data_i[DATA_WIDTH-1];
            rem_d  = amount;
            if (amount == '0) begin
              state_d  = StDone;
              result_d = rs1_data_i;
            end else begin
              state_d = StShift;
            end
          end
        end
        StShift: begin
          data_d = shifted;
          rem_d  = rem_q - step_k;
          if (rem_q == step_k) begin
            state_d  = StDone;
            result_d = shifted;
          end
        end
        StDone: begin
          if (rsp_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= StIdle;
      data_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq: scoreboarded results and latencies, backpressure,
// flush and asynchronous reset; a second instance covers SHIFT_STEP=4.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        flush;
  logic        req_valid, req_valid4;
  logic        req_ready, req_ready4;
  logic [1:0]  op;
  logic        use_imm;
  logic [31:0] rs1, rs2;
  logic [5:0]  imm;
  logic        rsp_valid, rsp_valid4;
  logic        rsp_ready;
  logic [31:0] result, result4;
  logic        busy, busy4;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  alu_shift_seq #(.DATA_WIDTH(32), .SHIFT_WIDTH(5), .SHIFT_STEP(1)) dut (
    .clk_i(clk), .arst_ni(arst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .op_i(op), .use_imm_i(use_imm), .rs1_data_i(rs1),
    .rs2_data_i(rs2), .imm_i(imm), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .result_o(result), .busy_o(busy)
  );

  alu_shift_seq #(.DATA_WIDTH(32), .SHIFT_WIDTH(5), .SHIFT_STEP(4)) dut4 (
    .clk_i(clk), .arst_ni(arst_n), .flush_i(flush), .req_valid_i(req_valid4),
    .req_ready_o(req_ready4), .op_i(op), .use_imm_i(use_imm), .rs1_data_i(rs1),
    .rs2_data_i(rs2), .imm_i(imm), .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready),
    .result_o(result4), .busy_o(busy4)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input logic [4:0] n);
    logic [5:0] back;
    back = 6'd32 - {1'b0, n};
    case (o)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b10:   return 32'($signed(a) >>> n);
      default: return (n == 5'd0) ? a : ((a >> n) | (a << back));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Enters and leaves aligned to a falling edge.
  task automatic do_op(input string tag, input logic [1:0] o, input logic ui,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] im,
                       input int stall);
    logic [4:0]  amt;
    logic [31:0] er;
    int          el;
    int          lat;
    amt = ui ? im[4:0] : b[4:0];
    exp_q.push_back(ref_shift(o, a, amt));
    lat_q.push_back(int'(amt) + 1);
    op = o; use_imm = ui; rs1 = a; rs2 = b; imm = im;
    req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    el = lat_q.pop_front();
    er = exp_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(el));
    if (lat != 0) begin
      check({tag, " result"}, result, er);
      for (int s = 0; s < stall; s++) begin
        check({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " stall result"}, result, er);
        check({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int seen;
    int lat4;
    arst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0;
    op = 2'b00; use_imm = 1'b0; rs1 = '0; rs2 = '0; imm = '0; rsp_ready = 1'b0;
    #12;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    do_op("sll3", 2'b00, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 6'd0, 0);
    do_op("sra4", 2'b10, 1'b1, 32'h8000_0000, 32'd0, 6'd4, 0);
    do_op("srl4", 2'b01, 1'b1, 32'h8000_0000, 32'd0, 6'd4, 0);
    do_op("ror1", 2'b11, 1'b0, 32'h0000_0001, 32'd1, 6'd0, 0);
    do_op("amt0", 2'b00, 1'b1, 32'hDEAD_BEEF, 32'd5, 6'h20, 0);
    do_op("sll31", 2'b00, 1'b1, 32'h0000_0001, 32'd0, 6'd31, 0);
    do_op("ror7", 2'b11, 1'b1, 32'h1234_5678, 32'd0, 6'd7, 0);
    do_op("sra_pos", 2'b10, 1'b0, 32'h7000_00F0, 32'h0000_0045, 6'd0, 0);
    do_op("stall", 2'b01, 1'b1, 32'hCAFE_F00D, 32'd0, 6'd2, 5);

    // STEP=4 instance: amount 31 takes ceil(31/4)=8 shift cycles.
    op = 2'b00; use_imm = 1'b1; rs1 = 32'h1; imm = 6'd31; rsp_ready = 1'b1;
    req_valid4 = 1'b1;
    @(posedge clk);
    #1 req_valid4 = 1'b0;
    lat4 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (rsp_valid4) begin
        lat4 = c;
        break;
      end
    end
    check("step4 latency", 32'(lat4), 32'd9);
    check("step4 result", result4, 32'h8000_0000);
    @(negedge clk);
    check("step4 idle", 32'(busy4), 32'd0);
    rsp_ready = 1'b0;

    // Flush in the second SHIFT cycle, with a competing request present.
    op = 2'b00; use_imm = 1'b1; rs1 = 32'h3; imm = 6'd10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    #1;
    check("flush req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush req_ready after", 32'(req_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("flush no response", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a shift.
    op = 2'b01; use_imm = 1'b1; rs1 = 32'hFFFF_0000; imm = 6'd20; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst req_ready", 32'(req_ready), 32'd0);
    check("arst result", result, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("arst no response", 32'(seen), 32'd0);

    do_op("post_reset", 2'b10, 1'b0, 32'h8000_0001, 32'd1, 6'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
